norm_row_div: RTL and testbench
===============================

// Module: norm_row_div
// PURPOSE
//  Row normalizer that sits directly downstream of the core output (out_core path).
//  Captures one row of `lanes` signed psums and sums their magnitudes.
//  Emits 256*|x_i|/sum(|x|) serially, one lane per cycle, lane 0 first.
//  The division uses a multi-cycle restoring divider, so there is no combinational divider.
// PARAMETERS
//  bw_psum  11  width of each signed input psum (2*bw+$clog2(pr) for bw=4, pr=8)
//  lanes    8   psums per row (col/2)
//  qbw      9   quotient width; fixed, because the result is at most 256
// PORTS
//  clk          in   1               clock
//  reset        in   1               asynchronous reset, active-high
//  psum_in      in   bw_psum*lanes   row of signed psums; lane i = psum_in[bw_psum*i +: bw_psum]
//  s_valid      in   1               row valid; sampled only when s_ready=1
//  s_ready      out  1               high only in IDLE
//  psum_norm    out  bw_psum         normalized value, zero-extended, range 0..256
//  norm_valid   out  1               psum_norm is valid this cycle
//  norm_lane    out  $clog2(lanes)   lane index of the current psum_norm
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, s_ready=1, psum_norm=0, norm_valid=0, norm_lane=0.
//   Captured row, magnitude sum and results are all cleared.
//  FSM states: IDLE -> SUM -> DIV -> OUT -> IDLE.
//  IDLE: at a posedge with s_valid=1, latch psum_in and go to SUM (call this edge E0).
//   s_ready falls in the same edge.
//  SUM: one lane per cycle, tot += |x_i|, for lanes cycles.
//   |x| is unsigned, bw_psum bits; -2^(bw_psum-1) maps to 2^(bw_psum-1) with no overflow.
//   tot width is bw_psum+$clog2(lanes), so it cannot overflow.
//  DIV: per lane, numerator = |x_i|<<8, denominator = tot.
//   One quotient bit per cycle, MSB first: qbw cycles per lane, lanes*qbw cycles total.
//   Each quotient is stored in a result register.
//   tot==0: division is skipped; every result is 0 and DIV still lasts lanes*qbw cycles.
//   This keeps latency fixed.
//  OUT: norm_valid=1 for exactly lanes consecutive cycles.
//   psum_norm = result[k] and norm_lane = k, k = 0..lanes-1.
//   Then IDLE; norm_valid and psum_norm return to 0 and s_ready rises.
//  Latency: first norm_valid=1 is visible after edge E0 + lanes + lanes*qbw + 1.
//   That is edge 81 for the default lanes=8.
//  Throughput: one row per 1 + lanes*(qbw+2) cycles. No pipelining across rows.
//  s_valid while s_ready=0: ignored; the row is not queued. psum_in is don't-care outside IDLE.
//  Exact result: q_i = floor(256*|x_i|/tot). Lanes are not renormalized, so the sum of q may be < 256.
// CONFIGURATION
//  NORM_ROUND_EN defined: numerator = (|x_i|<<8) + (tot>>1), giving round-half-up.
//   The result is saturated at 256. Latency is unchanged.
//  NORM_ROUND_EN undefined: truncating division as above.
// TESTING
//  T1 Uniform: all 8 lanes = 10.
//   -> tot=80; the 8 outputs are all 32; norm_lane 0..7; first valid at E0+81.
//  T2 Sign: lanes = {-20,20,0,0,0,0,0,0} (lane0 first).
//   -> 128,128,0,0,0,0,0,0.
//  T3 Extremes:
//   Lane0 = -1024, others 0 -> 256,0,...,0.
//   All-zero row -> eight 0s, norm_valid still high for 8 cycles.
//  T4 Rounding: lanes = {1,2,0,...}.
//   -> without NORM_ROUND_EN: 85,170,0,...
//   -> with NORM_ROUND_EN: 85,171,0,...
//  T5 Busy: pulse s_valid again 5 and 40 cycles after E0 with a different row.
//   -> both pulses ignored; output matches the first row only; s_ready=0 until OUT ends.
//  T6 Reset mid-DIV: assert reset 30 cycles after E0.
//   -> outputs 0 and s_ready=1 immediately; a next row (T1 data) yields eight 32s with nominal latency.

Source files
------------

// File: rtl/norm_row_div.sv
// rtl/norm_row_div.sv - row normalizer: emits 256*|x_i|/sum(|x|) one lane per cycle
// Optional feature macro: NORM_ROUND_EN (round-half-up with saturation at 256)
module norm_row_div #(
   parameter int bw_psum = 11,
   parameter int lanes   = 8,
   parameter int qbw     = 9
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [bw_psum*lanes-1:0]   psum_in,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic [bw_psum-1:0]         psum_norm,
   output logic                       norm_valid,
   output logic [$clog2(lanes)-1:0]   norm_lane
);

   localparam int lw = $clog2(lanes);
   localparam int tw = bw_psum + lw;       // magnitude sum width, cannot overflow
   localparam int nw = bw_psum + 9;        // numerator |x|<<8 plus rounding headroom
   localparam int dw = tw + qbw - 1;       // divisor shifted up to the quotient MSB
   localparam int cw = $clog2(qbw);

   typedef enum logic [1:0] {IDLE, SUM, DIV, OUT} state_t;

   state_t                     state, state_nxt;
   logic [bw_psum*lanes-1:0]   row;
   logic [tw-1:0]              tot;
   logic [lw-1:0]              lane;
   logic [cw-1:0]              bit_idx;
   logic [nw-1:0]              rem;
   logic [qbw-1:0]             quo;
   logic [qbw-1:0]             result [lanes];

   logic [bw_psum-1:0]         lane_x;
   logic [bw_psum-1:0]         mag;
   logic [nw-1:0]              num;
   logic [nw-1:0]              rem_cur;
   logic [dw-1:0]              rem_ext;
   logic [dw-1:0]              dsh;
   logic                       fits;
   logic [nw-1:0]              rem_nxt;
   logic [qbw-1:0]             quo_cur;
   logic [qbw-1:0]             quo_nxt;
   logic [qbw-1:0]             q_final;
   logic                       lane_last;
   logic                       bit_first;
   logic                       bit_last;

   assign lane_last = (lane == lw'(lanes - 1));
   assign bit_first = (bit_idx == cw'(qbw - 1));
   assign bit_last  = (bit_idx == '0);

   // Select the current lane of the captured row and take its magnitude
   always_comb begin
      lane_x = '0;
      for (int i = 0; i < lanes; i++) begin
         if (lane == lw'(i)) lane_x = row[i*bw_psum +: bw_psum];
      end
      // Two's-complement negate; the most negative value maps to 2^(bw_psum-1) unsigned
      mag = lane_x[bw_psum-1] ? (~lane_x + 1'b1) : lane_x;
   end

   // One restoring-division step: compare remainder against tot shifted to the current quotient bit
   always_comb begin
`ifdef NORM_ROUND_EN
      num = nw'({mag, 8'd0}) + nw'(tot >> 1);
`else
      num = nw'({mag, 8'd0});
`endif
      rem_cur = bit_first ? num : rem;
      quo_cur = bit_first ? '0 : quo;
      rem_ext = dw'(rem_cur);
      dsh     = dw'(tot) << bit_idx;
      fits    = (rem_ext >= dsh);
      rem_nxt = fits ? nw'(rem_ext - dsh) : rem_cur;
      quo_nxt = {quo_cur[qbw-2:0], fits};
`ifdef NORM_ROUND_EN
      q_final = (quo_nxt > qbw'(256)) ? qbw'(256) : quo_nxt;
`else
      q_final = quo_nxt;
`endif
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; s_ready is asserted only while idle
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      case (state)
         IDLE: begin
            s_ready = 1'b1;
            if (s_valid) state_nxt = SUM;
         end
         SUM:  if (lane_last) state_nxt = DIV;
         DIV:  if (lane_last && bit_last) state_nxt = OUT;
         OUT:  if (lane_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: row capture, magnitude accumulation, bit-serial divide, serial output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row        <= '0;
         tot        <= '0;
         lane       <= '0;
         bit_idx    <= '0;
         rem        <= '0;
         quo        <= '0;
         psum_norm  <= '0;
         norm_valid <= 1'b0;
         norm_lane  <= '0;
         for (int i = 0; i < lanes; i++) result[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               psum_norm  <= '0;
               norm_valid <= 1'b0;
               norm_lane  <= '0;
               if (s_valid) begin
                  row  <= psum_in;
                  tot  <= '0;
                  lane <= '0;
               end
            end
            SUM: begin
               tot  <= tot + tw'(mag);
               lane <= lane_last ? '0 : lane + 1'b1;
               if (lane_last) bit_idx <= cw'(qbw - 1);
            end
            DIV: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               if (bit_last) begin
                  // A zero row skips the quotient but keeps the fixed schedule
                  result[lane] <= (tot == '0) ? '0 : q_final;
                  bit_idx      <= cw'(qbw - 1);
                  lane         <= lane_last ? '0 : lane + 1'b1;
               end else begin
                  bit_idx <= bit_idx - 1'b1;
               end
            end
            OUT: begin
               psum_norm  <= bw_psum'(result[lane]);
               norm_valid <= 1'b1;
               norm_lane  <= lane;
               lane       <= lane_last ? '0 : lane + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_norm_row_div.sv
// tb/tb_norm_row_div.sv - table-driven checks for norm_row_div
module tb_norm_row_div;

   localparam int BW = 11;
   localparam int LN = 8;
   localparam int NV = 6;

   logic              clk;
   logic              reset;
   logic [BW*LN-1:0]  psum_in;
   logic              s_valid;
   logic              s_ready;
   logic [BW-1:0]     psum_norm;
   logic              norm_valid;
   logic [2:0]        norm_lane;

   int n_cmp = 0;
   int n_bad = 0;

   norm_row_div dut (
      .clk        (clk),
      .reset      (reset),
      .psum_in    (psum_in),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .psum_norm  (psum_norm),
      .norm_valid (norm_valid),
      .norm_lane  (norm_lane)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [BW*LN-1:0] row;
      logic [9*LN-1:0]  expq;
   } vec_t;

   vec_t vecs [NV];

   function automatic logic [BW*LN-1:0] mkrow(int a0, int a1, int a2, int a3,
                                              int a4, int a5, int a6, int a7);
      return {11'(a7), 11'(a6), 11'(a5), 11'(a4), 11'(a3), 11'(a2), 11'(a1), 11'(a0)};
   endfunction

   function automatic logic [9*LN-1:0] mkexp(int a0, int a1, int a2, int a3,
                                             int a4, int a5, int a6, int a7);
      return {9'(a7), 9'(a6), 9'(a5), 9'(a4), 9'(a3), 9'(a2), 9'(a1), 9'(a0)};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one row from a posedge+1 point and checks latency, the eight outputs and the return to idle.
   // With busy set, a different row is offered 5 and 40 edges after the accepting edge.
   task automatic apply_row(input logic [BW*LN-1:0] row, input logic [9*LN-1:0] expq,
                            input bit busy, input int id);
      int n;
      bit ready_low;
      int w;
      w = 0;
      while (!s_ready && w < 200) begin
         tick();
         w++;
      end
      chk($sformatf("v%0d ready_before", id), int'(s_ready), 1);
      psum_in = row;
      s_valid = 1'b1;
      tick();                               // edge E0
      s_valid = 1'b0;
      psum_in = {(BW*LN){1'b1}};
      chk($sformatf("v%0d ready_after_accept", id), int'(s_ready), 0);
      n = 0;
      ready_low = 1'b1;
      while (!norm_valid && n < 200) begin
         if (busy && (n == 4 || n == 39)) begin
            s_valid = 1'b1;
            psum_in = mkrow(300, 300, 300, 300, 300, 300, 300, 1);
         end else begin
            s_valid = 1'b0;
         end
         tick();
         n++;
         if (s_ready) ready_low = 1'b0;
      end
      s_valid = 1'b0;
      chk($sformatf("v%0d latency", id), n, 81);
      if (busy) chk($sformatf("v%0d busy_ready_low", id), int'(ready_low), 1);
      for (int k = 0; k < LN; k++) begin
         chk($sformatf("v%0d lane%0d valid", id, k), int'(norm_valid), 1);
         chk($sformatf("v%0d lane%0d index", id, k), int'(norm_lane), k);
         chk($sformatf("v%0d lane%0d value", id, k), int'(psum_norm), int'(expq[9*k +: 9]));
         if (k < LN - 1 && busy)
            chk($sformatf("v%0d lane%0d ready", id, k), int'(s_ready), 0);
         tick();
      end
      chk($sformatf("v%0d valid_drop", id), int'(norm_valid), 0);
      chk($sformatf("v%0d norm_zero", id), int'(psum_norm), 0);
      chk($sformatf("v%0d ready_back", id), int'(s_ready), 1);
   endtask

   initial begin
      vecs[0].row  = mkrow(10, 10, 10, 10, 10, 10, 10, 10);
      vecs[0].expq = mkexp(32, 32, 32, 32, 32, 32, 32, 32);
      vecs[1].row  = mkrow(-20, 20, 0, 0, 0, 0, 0, 0);
      vecs[1].expq = mkexp(128, 128, 0, 0, 0, 0, 0, 0);
      vecs[2].row  = mkrow(-1024, 0, 0, 0, 0, 0, 0, 0);
      vecs[2].expq = mkexp(256, 0, 0, 0, 0, 0, 0, 0);
      vecs[3].row  = mkrow(0, 0, 0, 0, 0, 0, 0, 0);
      vecs[3].expq = mkexp(0, 0, 0, 0, 0, 0, 0, 0);
      vecs[4].row  = mkrow(1, 2, 0, 0, 0, 0, 0, 0);
`ifdef NORM_ROUND_EN
      vecs[4].expq = mkexp(85, 171, 0, 0, 0, 0, 0, 0);
`else
      vecs[4].expq = mkexp(85, 170, 0, 0, 0, 0, 0, 0);
`endif
      vecs[5].row  = mkrow(100, -50, 25, -25, 0, 0, 0, 300);
`ifdef NORM_ROUND_EN
      vecs[5].expq = mkexp(51, 26, 13, 13, 0, 0, 0, 154);
`else
      vecs[5].expq = mkexp(51, 25, 12, 12, 0, 0, 0, 153);
`endif

      reset   = 1'b1;
      s_valid = 1'b0;
      psum_in = '0;
      repeat (3) tick();
      chk("reset s_ready", int'(s_ready), 1);
      chk("reset norm_valid", int'(norm_valid), 0);
      chk("reset psum_norm", int'(psum_norm), 0);
      chk("reset norm_lane", int'(norm_lane), 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < NV; i++) apply_row(vecs[i].row, vecs[i].expq, 1'b0, i);

      // Busy: re-offered rows during SUM and DIV must be dropped
      apply_row(vecs[1].row, vecs[1].expq, 1'b1, 10);

      // Reset in the middle of DIV, then a fresh row at nominal latency
      psum_in = vecs[5].row;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      repeat (30) tick();
      reset = 1'b1;
      #1;
      chk("midreset s_ready", int'(s_ready), 1);
      chk("midreset norm_valid", int'(norm_valid), 0);
      chk("midreset psum_norm", int'(psum_norm), 0);
      chk("midreset norm_lane", int'(norm_lane), 0);
      #2;
      reset = 1'b0;
      tick();
      chk("postreset norm_valid", int'(norm_valid), 0);
      apply_row(vecs[0].row, vecs[0].expq, 1'b0, 11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
